// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two operation request ports sharing one
// result payload, with a per-requester valid/ready response channel.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_in1;
  logic [15:0] req0_in2;
  logic [15:0] req1_in1;
  logic [15:0] req1_in2;
  logic [2:0]  req0_op;
  logic [2:0]  req1_op;
  logic        req0_inv;
  logic        req1_inv;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_data;
  logic        resp_zero;
  logic        resp_ovf;
  logic        resp_neg;
  logic        resp_err;

  modport master (
    output req_valid, req0_in1, req0_in2, req1_in1, req1_in2,
    output req0_op, req1_op, req0_inv, req1_inv, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_zero, resp_ovf, resp_neg, resp_err
  );

  modport slave (
    input  req_valid, req0_in1, req0_in2, req1_in1, req1_in2,
    input  req0_op, req1_op, req0_inv, req1_inv, resp_ready,
    output req_ready, resp_valid, resp_data, resp_zero, resp_ovf, resp_neg, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer for the shared 16-bit ALU: grants one operation at a time,
// drives the ALU for one cycle, captures result and flags, and returns them to the winner.
module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic [15:0]  alu_in1,
  output logic [15:0]  alu_in2,
  output logic [4:0]   alu_opcode,
  output logic         alu_inv,
  output logic         alu_sub,
  output logic         alu_ovwA,
  input  logic [15:0]  alu_out,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         alu_neg
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_t      state, state_n;
  logic        ptr;
  logic        gnt;
  logic        win;
  logic        accept;
  logic [15:0] in1_p0, in2_p0;
  logic [2:0]  op_p0;
  logic        inv_p0;

  // Returns {alu_opcode, alu_sub}; CLR and the illegal code leave the ALU idle.
  function automatic logic [5:0] map_op(input logic [2:0] op);
    case (op)
      3'b000:  map_op = 6'b00001_0;
      3'b001:  map_op = 6'b00001_1;
      3'b010:  map_op = 6'b00010_0;
      3'b011:  map_op = 6'b00100_0;
      3'b100:  map_op = 6'b01000_0;
      3'b101:  map_op = 6'b10000_0;
      default: map_op = 6'b00000_0;
    endcase
  endfunction

  always_comb begin
    win = 1'b0;
    if (bus.req_valid == 2'b10)
      win = 1'b1;
    else if (bus.req_valid == 2'b11 && RR)
      win = ptr;
  end

  // Reset wins over a simultaneous request, so no grant is offered while rst is high.
  assign accept   = (state == IDLE) && !rst && (|bus.req_valid);
  assign busy     = (state != IDLE);
  assign alu_ovwA = 1'b1;

  always_comb begin
    state_n        = state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    alu_in1        = '0;
    alu_in2        = '0;
    alu_opcode     = '0;
    alu_sub        = 1'b0;
    alu_inv        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready = win ? 2'b10 : 2'b01;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        alu_in1               = in1_p0;
        alu_in2               = in2_p0;
        {alu_opcode, alu_sub} = map_op(op_p0);
        alu_inv               = inv_p0 && (op_p0 != OP_CLR) && (op_p0 != OP_ILL);
        state_n               = CAPTURE;
      end
      CAPTURE: state_n = RESP;
      RESP: begin
        bus.resp_valid = gnt ? 2'b10 : 2'b01;
        if (bus.resp_ready[gnt])
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      gnt   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept)
        gnt <= win;
      if (state == RESP && bus.resp_ready[gnt])
        ptr <= ~gnt;
    end
  end

  // Stage p0: operation latched at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      in1_p0 <= win ? bus.req1_in1 : bus.req0_in1;
      in2_p0 <= win ? bus.req1_in2 : bus.req0_in2;
      op_p0  <= win ? bus.req1_op  : bus.req0_op;
      inv_p0 <= win ? bus.req1_inv : bus.req0_inv;
    end
  end

  // Response registers: loaded once in CAPTURE, then held through any backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_data <= '0;
      bus.resp_zero <= 1'b0;
      bus.resp_ovf  <= 1'b0;
      bus.resp_neg  <= 1'b0;
      bus.resp_err  <= 1'b0;
    end else if (state == CAPTURE) begin
      if (op_p0 == OP_ILL) begin
        bus.resp_data <= '0;
        bus.resp_zero <= 1'b1;
        bus.resp_ovf  <= 1'b0;
        bus.resp_neg  <= 1'b0;
        bus.resp_err  <= 1'b1;
      end else begin
        bus.resp_data <= alu_out;
        bus.resp_zero <= alu_zero;
        bus.resp_ovf  <= alu_overflow;
        bus.resp_neg  <= alu_neg;
        bus.resp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance driven with identical
// stimulus, each fed by a small registered ALU stub and checked every cycle against a model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus_a ();
  alu_arbiter_if bus_b ();

  logic [1:0]  rv, rr_rdy;
  logic [15:0] r0a, r0b, r1a, r1b;
  logic [2:0]  r0op, r1op;
  logic        r0inv, r1inv;

  assign bus_a.req_valid = rv;     assign bus_b.req_valid = rv;
  assign bus_a.resp_ready = rr_rdy; assign bus_b.resp_ready = rr_rdy;
  assign bus_a.req0_in1 = r0a;     assign bus_b.req0_in1 = r0a;
  assign bus_a.req0_in2 = r0b;     assign bus_b.req0_in2 = r0b;
  assign bus_a.req1_in1 = r1a;     assign bus_b.req1_in1 = r1a;
  assign bus_a.req1_in2 = r1b;     assign bus_b.req1_in2 = r1b;
  assign bus_a.req0_op = r0op;     assign bus_b.req0_op = r0op;
  assign bus_a.req1_op = r1op;     assign bus_b.req1_op = r1op;
  assign bus_a.req0_inv = r0inv;   assign bus_b.req0_inv = r0inv;
  assign bus_a.req1_inv = r1inv;   assign bus_b.req1_inv = r1inv;

  logic [15:0] alu_in1 [2];
  logic [15:0] alu_in2 [2];
  logic [4:0]  alu_opc [2];
  logic        alu_inv [2];
  logic        alu_sub [2];
  logic        alu_ovw [2];
  logic        busy [2];
  logic [18:0] alu_res [2];   // {overflow, zero, neg, result}

  alu_arbiter #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy[0]),
    .alu_in1(alu_in1[0]), .alu_in2(alu_in2[0]), .alu_opcode(alu_opc[0]),
    .alu_inv(alu_inv[0]), .alu_sub(alu_sub[0]), .alu_ovwA(alu_ovw[0]),
    .alu_out(alu_res[0][15:0]), .alu_zero(alu_res[0][17]),
    .alu_overflow(alu_res[0][18]), .alu_neg(alu_res[0][16])
  );

  alu_arbiter #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy[1]),
    .alu_in1(alu_in1[1]), .alu_in2(alu_in2[1]), .alu_opcode(alu_opc[1]),
    .alu_inv(alu_inv[1]), .alu_sub(alu_sub[1]), .alu_ovwA(alu_ovw[1]),
    .alu_out(alu_res[1][15:0]), .alu_zero(alu_res[1][17]),
    .alu_overflow(alu_res[1][18]), .alu_neg(alu_res[1][16])
  );

  // ALU stub: registers its inputs on every edge, outputs follow combinationally.
  logic [15:0] a_r [2];
  logic [15:0] b_r [2];
  logic [4:0]  opc_r [2];
  logic        sub_r [2];
  logic        inv_r [2];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      a_r[k]   <= alu_in1[k];
      b_r[k]   <= alu_in2[k];
      opc_r[k] <= alu_opc[k];
      sub_r[k] <= alu_sub[k];
      inv_r[k] <= alu_inv[k];
    end
  end

  function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] opc, input logic sub, input logic inv);
    logic [31:0] p;
    logic [15:0] r;
    logic        ovf;
    r = '0; ovf = 1'b0;
    case (opc)
      5'b00001: begin
        r   = sub ? a - b : a + b;
        ovf = sub ? ((a[15] != b[15]) && (r[15] != a[15])) : ((a[15] == b[15]) && (r[15] != a[15]));
      end
      5'b00010: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; ovf = |p[31:16]; end
      5'b00100: r = a & b;
      5'b01000: r = a | b;
      5'b10000: r = a ^ b;
      default:  r = '0;
    endcase
    if (inv) r = ~r;
    return {ovf, r == 16'h0, r[15], r};
  endfunction

  assign alu_res[0] = alu_fn(a_r[0], b_r[0], opc_r[0], sub_r[0], inv_r[0]);
  assign alu_res[1] = alu_fn(a_r[1], b_r[1], opc_r[1], sub_r[1], inv_r[1]);

  int errors = 0;
  int checks = 0;

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h, expected %0h", k, name, act, exp);
    end
  endtask

  // Expected {err, ovf, zero, neg, data} from the operation's arithmetic meaning.
  function automatic logic [19:0] exp_res(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic inv);
    int sa, sb, s;
    longint unsigned p;
    logic [15:0] r;
    logic ovf;
    sa = $signed(a); sb = $signed(b);
    r = '0; ovf = 1'b0; s = 0;
    case (op)
      3'd0: begin s = sa + sb; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      3'd2: begin p = longint'(a) * longint'(b); r = p[15:0]; ovf = (p > 65535); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      default: r = '0;
    endcase
    if (op == 3'd7) return {4'b1010, 16'h0000};
    if (op <= 3'd5 && inv) r = ~r;
    return {1'b0, ovf, r == 16'h0, r[15], r};
  endfunction

  function automatic logic [5:0] exp_ctl(input logic [2:0] op);
    case (op)
      3'd0: return 6'b00001_0;
      3'd1: return 6'b00001_1;
      3'd2: return 6'b00010_0;
      3'd3: return 6'b00100_0;
      3'd4: return 6'b01000_0;
      3'd5: return 6'b10000_0;
      default: return 6'b00000_0;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [15:0] data;
    logic        z, o, n, e;
    logic        busy;
    logic [15:0] i1, i2;
    logic [4:0]  opc;
    logic        sub, inv, ovw;
  } obs_t;

  // Model: one in-flight operation per instance, tracked by cycles since accept.
  bit          inflight [2];
  int          age [2];
  logic        ptr [2];
  logic        g [2];
  logic [2:0]  m_op [2];
  logic [15:0] m_a [2];
  logic [15:0] m_b [2];
  logic        m_inv [2];
  int          acc_cnt [2];
  int          done_cnt [2];
  int          n_g1 [2];
  logic [1:0]  last_rdy [2];
  logic [1:0]  last_rv [2];
  logic [15:0] last_data [2];
  logic [3:0]  last_flags [2];   // {err, ovf, zero, neg}

  function automatic logic pick(input int k);
    if (rv == 2'b10) return 1'b1;
    if (rv == 2'b11 && k == 0) return ptr[k];
    return 1'b0;
  endfunction

  task automatic model(input int k, input obs_t o);
    logic        w;
    logic [1:0]  w_oh;
    logic [19:0] e;
    logic [5:0]  c;
    check(k, "alu_ovwA", 32'(o.ovw), 32'd1);
    if (!inflight[k]) begin
      w    = pick(k);
      w_oh = (rst || rv == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
      check(k, "idle req_ready", 32'(o.rdy), 32'(w_oh));
      check(k, "idle resp_valid", 32'(o.rv), 32'd0);
      check(k, "idle busy", 32'(o.busy), 32'd0);
      check(k, "idle alu operands", {o.i1, o.i2}, 32'd0);
      check(k, "idle alu ctl", 32'({o.opc, o.sub, o.inv}), 32'd0);
    end else begin
      check(k, "busy in flight", 32'(o.busy), 32'd1);
      check(k, "req_ready in flight", 32'(o.rdy), 32'd0);
      if (age[k] == 0) begin
        c = exp_ctl(m_op[k]);
        check(k, "issue operands", {o.i1, o.i2}, {m_a[k], m_b[k]});
        check(k, "issue ctl", 32'({o.opc, o.sub, o.inv}), 32'({c, m_inv[k] && (m_op[k] < 3'd6)}));
        check(k, "issue resp_valid", 32'(o.rv), 32'd0);
      end else if (age[k] == 1) begin
        check(k, "capture resp_valid", 32'(o.rv), 32'd0);
        check(k, "capture alu operands", {o.i1, o.i2}, 32'd0);
      end else begin
        e = exp_res(m_op[k], m_a[k], m_b[k], m_inv[k]);
        check(k, "resp_valid", 32'(o.rv), g[k] ? 32'd2 : 32'd1);
        check(k, "resp_data", 32'(o.data), 32'(e[15:0]));
        check(k, "resp flags err/ovf/zero/neg", 32'({o.e, o.o, o.z, o.n}), 32'(e[19:16]));
      end
    end
    if (rst) begin
      inflight[k] = 1'b0;
      ptr[k]      = 1'b0;
    end else if (!inflight[k]) begin
      if (rv != 2'b00) begin
        w           = pick(k);
        g[k]        = w;
        m_op[k]     = w ? r1op : r0op;
        m_a[k]      = w ? r1a : r0a;
        m_b[k]      = w ? r1b : r0b;
        m_inv[k]    = w ? r1inv : r0inv;
        inflight[k] = 1'b1;
        age[k]      = 0;
        acc_cnt[k]++;
        if (w) n_g1[k]++;
        last_rdy[k] = o.rdy;
      end
    end else if (age[k] >= 2) begin
      if (rr_rdy[g[k]]) begin
        inflight[k] = 1'b0;
        ptr[k]      = !g[k];
        done_cnt[k]++;
        last_rv[k]    = o.rv;
        last_data[k]  = o.data;
        last_flags[k] = {o.e, o.o, o.z, o.n};
      end
    end else begin
      age[k]++;
    end
  endtask

  task automatic step();
    obs_t oa, ob;
    @(negedge clk);
    oa = {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_data, bus_a.resp_zero, bus_a.resp_ovf,
          bus_a.resp_neg, bus_a.resp_err, busy[0], alu_in1[0], alu_in2[0], alu_opc[0],
          alu_sub[0], alu_inv[0], alu_ovw[0]};
    ob = {bus_b.req_ready, bus_b.resp_valid, bus_b.resp_data, bus_b.resp_zero, bus_b.resp_ovf,
          bus_b.resp_neg, bus_b.resp_err, busy[1], alu_in1[1], alu_in2[1], alu_opc[1],
          alu_sub[1], alu_inv[1], alu_ovw[1]};
    model(0, oa);
    model(1, ob);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc();
    int start = acc_cnt[0];
    int n = 0;
    while (acc_cnt[0] == start && n < 30) begin step(); n++; end
    if (acc_cnt[0] == start) begin
      checks++; errors++;
      $display("FAIL accept timeout: no accept after %0d cycles, expected within 30", n);
    end
  endtask

  task automatic wait_done(input int bound);
    int start = done_cnt[0];
    int n = 0;
    while (done_cnt[0] == start && n < bound) begin step(); n++; end
    if (done_cnt[0] == start) begin
      checks++; errors++;
      $display("FAIL response timeout: no handshake after %0d cycles, expected within %0d", n, bound);
    end
  endtask

  task automatic run_op(input int i, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic inv);
    if (i == 0) begin r0op = op; r0a = a; r0b = b; r0inv = inv; rv = 2'b01; end
    else        begin r1op = op; r1a = a; r1b = b; r1inv = inv; rv = 2'b10; end
    wait_acc();
    rv = 2'b00;
    wait_done(20);
  endtask

  task automatic check_last(input string name, input logic [15:0] data, input logic [3:0] flags,
                            input logic [1:0] rvx);
    for (int k = 0; k < 2; k++) begin
      check(k, {name, " data"}, 32'(last_data[k]), 32'(data));
      check(k, {name, " flags"}, 32'(last_flags[k]), 32'(flags));
      check(k, {name, " resp_valid"}, 32'(last_rv[k]), 32'(rvx));
    end
  endtask

  initial begin
    int s_done, s_g0, s_g1, n;
    rst = 1'b1; rv = 2'b00; rr_rdy = 2'b11;
    r0a = '0; r0b = '0; r1a = '0; r1b = '0; r0op = '0; r1op = '0; r0inv = 1'b0; r1inv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      inflight[k] = 1'b0; ptr[k] = 1'b0; g[k] = 1'b0; age[k] = 0;
      acc_cnt[k] = 0; done_cnt[k] = 0; n_g1[k] = 0;
    end
    @(posedge clk);
    #1;
    check(0, "reset outputs", 32'({bus_a.resp_data, bus_a.resp_valid, bus_a.req_ready, bus_a.resp_zero,
          bus_a.resp_ovf, bus_a.resp_neg, bus_a.resp_err, busy[0], alu_ovw[0]}), 32'd1);
    check(1, "reset outputs", 32'({bus_b.resp_data, bus_b.resp_valid, bus_b.req_ready, bus_b.resp_zero,
          bus_b.resp_ovf, bus_b.resp_neg, bus_b.resp_err, busy[1], alu_ovw[1]}), 32'd1);
    step();
    rst = 1'b0;
    step();

    run_op(0, 3'd0, 16'h0003, 16'h0004, 1'b0);
    check_last("add 3+4", 16'h0007, 4'b0000, 2'b01);
    run_op(1, 3'd1, 16'h0005, 16'h0005, 1'b0);
    check_last("sub 5-5", 16'h0000, 4'b0010, 2'b10);
    run_op(1, 3'd1, 16'h0002, 16'h0005, 1'b0);
    check_last("sub 2-5", 16'hFFFD, 4'b0001, 2'b10);
    run_op(0, 3'd2, 16'h0100, 16'h0100, 1'b0);
    check_last("mul overflow", 16'h0000, 4'b0110, 2'b01);
    run_op(0, 3'd3, 16'h00FF, 16'h0F0F, 1'b1);
    check_last("and inverted", 16'hFFF0, 4'b0001, 2'b01);
    run_op(0, 3'd6, 16'h1234, 16'h5678, 1'b1);
    check_last("clr ignores inv", 16'h0000, 4'b0010, 2'b01);
    run_op(1, 3'd4, 16'h1200, 16'h0034, 1'b0);
    check_last("or", 16'h1234, 4'b0000, 2'b10);

    // Both requesters held valid for eight operations
    r0op = 3'd0; r0a = 16'h0001; r0b = 16'h0002; r0inv = 1'b0;
    r1op = 3'd5; r1a = 16'hF0F0; r1b = 16'h0FF0; r1inv = 1'b0;
    s_done = done_cnt[0]; s_g0 = n_g1[0]; s_g1 = n_g1[1]; n = 0;
    rv = 2'b11;
    while (done_cnt[0] - s_done < 8 && n < 100) begin step(); n++; end
    rv = 2'b00;
    check(0, "ops completed with both valid", 32'(done_cnt[0] - s_done), 32'd8);
    check(0, "round-robin grants to req1", 32'(n_g1[0] - s_g0), 32'd4);
    check(1, "fixed-priority grants to req1", 32'(n_g1[1] - s_g1), 32'd0);

    // Illegal op under response backpressure
    rr_rdy = 2'b00;
    r0op = 3'd7; r0a = 16'hAAAA; r0b = 16'h5555; r0inv = 1'b1; rv = 2'b01;
    wait_acc();
    rv = 2'b00;
    n = 0;
    while (age[0] < 2 && n < 10) begin step(); n++; end
    for (int i = 0; i < 5; i++) step();
    rr_rdy = 2'b10;
    step();
    check(0, "non-granted resp_ready ignored", 32'({bus_a.resp_valid, busy[0]}), 32'b011);
    check(1, "non-granted resp_ready ignored", 32'({bus_b.resp_valid, busy[1]}), 32'b011);
    rr_rdy = 2'b11;
    wait_done(5);
    check_last("illegal op", 16'h0000, 4'b1010, 2'b01);

    // Reset while in CAPTURE discards the operation and the pointer
    r0op = 3'd0; r0a = 16'h0009; r0b = 16'h0009; r0inv = 1'b0; rv = 2'b01;
    wait_acc();
    rv = 2'b00;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check(0, "after reset busy/resp_valid", 32'({busy[0], bus_a.resp_valid}), 32'd0);
    check(1, "after reset busy/resp_valid", 32'({busy[1], bus_b.resp_valid}), 32'd0);
    r0op = 3'd0; r0a = 16'h7FFF; r0b = 16'h0001; r0inv = 1'b0;
    r1op = 3'd4; r1a = 16'h0F00; r1b = 16'h00F0; r1inv = 1'b0;
    rv = 2'b11;
    wait_acc();
    rv = 2'b00;
    check(0, "first grant after reset", 32'(last_rdy[0]), 32'd1);
    check(1, "first grant after reset", 32'(last_rdy[1]), 32'd1);
    wait_done(20);
    check_last("add signed overflow", 16'h8000, 4'b0101, 2'b01);
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 16-bit ALU. Accepts one operation at a time from either of two requesters, translates it to the ALU's one-hot opcode/sub/inv controls, and waits out the ALU's input-register latency. Captures result and flags, then returns them to the granted requester over a valid/ready response channel. Sits between the ALU and its clients; it is the only driver of the ALU inputs.

## Interface
- RR, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester operation valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_in1, req0_in2, req1_in1, req1_in2  in  16 each  operands
- req0_op, req1_op  in  3 each  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 CLR, 111 illegal
- req0_inv, req1_inv  in  1 each  invert ALU result
- resp_valid  out  2  per-requester result valid; one-hot or zero
- resp_ready  in  2  per-requester result accept
- resp_data  out  16  result
- resp_zero, resp_ovf, resp_neg, resp_err  out  1 each  captured flags; err = illegal op
- busy  out  1  high in any state other than IDLE
- alu_in1, alu_in2  out  16  to ALU operand inputs
- alu_opcode  out  5  to ALU opcode
- alu_inv, alu_sub, alu_ovwA  out  1 each  to ALU controls
- alu_out  in  16  ALU result
- alu_zero, alu_overflow, alu_neg  in  1 each  ALU flags

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP. One operation in flight at a time.
- Grant selection in IDLE:
  - Only one valid: that requester wins.
  - Both valid, RR=1: the requester not served last wins. Pointer resets to "requester 0 next".
  - Both valid, RR=0: requester 0 wins.
- IDLE:
  - If any req_valid: req_ready[g]=1 combinationally for the winner g. Latch g, operands, op, inv. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: drive the ALU from the latched operation and go to CAPTURE. The ALU registers its inputs on this cycle's closing edge.
- CAPTURE:
  - ALU outputs now reflect the operation; capture alu_out and the flags into response registers. Go to RESP.
  - Illegal op: resp_data=0x0000, resp_zero=1, resp_ovf=0, resp_neg=0, resp_err=1. Otherwise resp_err=0.
- RESP:
  - resp_valid[g]=1 with registered data and flags held stable.
  - On resp_ready[g]: update the RR pointer to favour the other requester and go to IDLE. resp_ready of the non-granted requester is ignored.
- Op mapping to (alu_opcode, alu_sub):
  - ADD 00001/0, SUB 00001/1, MUL 00010/0, AND 00100/0, OR 01000/0, XOR 10000/0.
  - CLR and illegal 00000/0.
  - alu_inv = latched inv; forced 0 for CLR and illegal.
- alu_ovwA = 1 in every state, so the ALU's A register always loads alu_in1. The controller never uses accumulation.
- Outside ISSUE, the ALU inputs are driven as: alu_in1=0, alu_in2=0, alu_opcode=00000, alu_sub=0, alu_inv=0.
- Widths: all data 16-bit, no extension. Flags are passed through from the ALU unmodified.

## Timing
- Reset values:
  - State IDLE, RR pointer = requester 0.
  - req_ready=00, resp_valid=00, resp_data=0x0000, all resp flags 0, busy=0.
  - ALU drive at idle values, alu_ovwA=1.
- Accept edge is T0. States by cycle: ISSUE T0–T1, CAPTURE T1–T2, RESP from T2.
- resp_valid is visible during the cycle after edge T2. Minimum accept-to-response latency is 3 cycles.
- Back-to-back: the earliest next accept is the cycle after the resp_ready handshake. Peak throughput is 1 operation per 4 cycles.
- req_ready is asserted only in IDLE.
- A requester holding req_valid while another is served is not accepted and must keep its operands stable.
- rst during any state:
  - Returns to IDLE next edge and discards the in-flight operation; no resp_valid is produced.
  - Pointer returns to requester 0.
  - rst has priority over a simultaneous req_valid.
- Response backpressure: data and flags are held unchanged for any number of cycles with resp_ready=0.

## Test plan
- req0 ADD 0x0003, 0x0004, inv=0 -> req_ready=01 at T0, resp_valid=01 after T2, resp_data=0x0007, zero=0, err=0.
- req1 SUB 0x0005, 0x0005 -> resp_valid=10, resp_data=0x0000, zero=1. Then req1 SUB 0x0002, 0x0005 -> resp_data=0xFFFD.
- req0 MUL 0x0100, 0x0100 -> resp_ovf=1. Then req0 AND 0x00FF, 0x0F0F with inv=1 -> resp_data=0xFFF0.
- Both requesters held valid for 8 operations, RR=1 -> grants 0,1,0,1,... Repeat with RR=0 -> all grants go to requester 0.
- req0 op 111 -> resp_err=1, resp_data=0x0000, zero=1. Hold resp_ready=0 for 5 cycles -> outputs stable, busy=1 throughout.
- Assert rst for one cycle in CAPTURE -> no resp_valid, busy=0 next cycle. Then both requesters valid -> requester 0 granted first.
